// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
// Holds the access-size and FSM state encodings, the default memory depth
// and a helper that builds the low-bit mask for an access size.
package lsu_pkg;
    localparam int DEF_MEM_DEPTH = 128;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [2:0] {IDLE, CHK, RD, WR, RESP} state_e;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        return (sz == SZ_D) ? '1 : (64'd1 << (8 << sz)) - 64'd1;
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian lane extract (load) and lane merge (store).
// Ports:
//   i_rd_buf  doubleword read from memory
//   i_off     byte offset within the doubleword
//   i_size    access size (SZ_B..SZ_D)
//   i_signed  sign-extend the extracted field
//   i_wdata   right-justified store data
//   o_rdata   extracted, extended load result
//   o_wmerge  i_rd_buf with the addressed lane replaced by i_wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] i_rd_buf,
    input  logic [2:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_rdata,
    output logic [63:0] o_wmerge
);
    logic [3:0]  w_end;
    logic [6:0]  w_sh;
    logic [63:0] w_mask;
    logic [63:0] w_field;
    logic        w_msb;

    // Field ends at byte o+n counted from the MSB, so its LSB sits 64-8(o+n) bits up.
    assign w_end    = {1'b0, i_off} + (4'd1 << i_size);
    assign w_sh     = 7'd64 - {w_end, 3'b000};
    assign w_mask   = size_mask(i_size);
    assign w_field  = (i_rd_buf >> w_sh) & w_mask;
    assign w_msb    = (i_size == SZ_B) ? w_field[7] :
                      (i_size == SZ_H) ? w_field[15] :
                      (i_size == SZ_W) ? w_field[31] : 1'b0;
    assign o_rdata  = (i_signed && w_msb) ? (w_field | ~w_mask) : w_field;
    assign o_wmerge = (i_rd_buf & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a doubleword memory.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*                    request handshake and fields (valid/ready)
//   resp_valid/rdata/err     one-cycle completion with load data or error
//   mem_read_*               combinational-read memory port (doubleword index)
//   mem_write_*              posedge-write memory port (doubleword index)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 64,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data
);
    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic              r_store;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_buf;
    logic              r_err;
    logic [ADDR_W-1:0] w_index;
    logic              w_bad;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_merge;

    assign w_index = {3'b000, r_addr[ADDR_W-1:3]};
    assign w_bad   = ((r_addr[2:0] & ((3'd1 << r_size) - 3'd1)) != 3'd0)
                     || (w_index >= ADDR_W'(MEM_DEPTH));

    lsu_lane_align u_align (
        .i_rd_buf (r_rd_buf),
        .i_off    (r_addr[2:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_rdata  (w_load),
        .o_wmerge (w_merge)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Outputs are gated by rst so a reset in any state suppresses writes and responses.
    always_comb begin
        w_next         = r_state;
        req_ready      = (r_state == IDLE) && !rst;
        mem_read_en    = (r_state == RD) && !rst;
        mem_write_en   = (r_state == WR) && !rst;
        resp_valid     = (r_state == RESP) && !rst;
        mem_read_addr  = mem_read_en ? w_index : '0;
        mem_write_addr = mem_write_en ? w_index : '0;
        mem_write_data = mem_write_en ? w_merge : '0;
        resp_err       = resp_valid && r_err;
        resp_rdata     = (resp_valid && !r_err && !r_store) ? w_load : '0;
        case (r_state)
            IDLE:    w_next = req_valid ? CHK : IDLE;
            CHK:     w_next = w_bad ? RESP : (r_store && r_size == SZ_D) ? WR : RD;
            RD:      w_next = r_store ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_store  <= 1'b0;
            r_wdata  <= '0;
            r_rd_buf <= '0;
            r_err    <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                r_addr   <= req_addr;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_store  <= req_is_store;
                r_wdata  <= req_wdata;
            end
            if (r_state == CHK)
                r_err <= w_bad;
            if (r_state == RD)
                r_rd_buf <= mem_read_data;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a 128 x 64 memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_read_en;
    logic [63:0] mem_read_addr;
    logic [63:0] mem_read_data;
    logic        mem_write_en;
    logic [63:0] mem_write_addr;
    logic [63:0] mem_write_data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_read_en    (mem_read_en),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    logic [63:0] mem [0:127];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_idx = '0;
    logic [63:0] pl_data = '0;
    int          wr_cnt = 0;

    assign mem_read_data = mem[mem_read_addr[6:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_write_addr[6:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (pl_en)
            mem[pl_idx] <= pl_data;
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   passed = 0;
    int   neg_cnt = 0;
    int   rd_cnt = 0;
    int   resp_cnt = 0;
    bit   both = 1'b0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    // Monitor: counts negedges, tallies read-enable cycles, scores every response.
    always @(negedge clk) begin
        neg_cnt++;
        if (mem_read_en)
            rd_cnt++;
        if (mem_read_en && mem_write_en)
            both = 1'b1;
        if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_resp", 64'd1, 64'd0);
            end else begin
                m_e = sb.pop_front();
                chk("resp_rdata", resp_rdata, m_e.rdata);
                chk("resp_err", {63'd0, resp_err}, {63'd0, m_e.err});
                chk("latency", 64'(neg_cnt - m_e.t0), 64'(m_e.lat));
            end
        end
    end

    task automatic preload(input logic [6:0] idx, input logic [63:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic op(input logic st, input logic [1:0] sz, input logic sg,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] er, input logic ee, input int lat,
                      input int nrd, input int nwr);
        int rd0, wr0, r0, k;
        @(negedge clk);
        #1;
        req_is_store = st;
        req_size     = sz;
        req_signed   = sg;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        r0  = resp_cnt;
        sb.push_back('{er, ee, lat, neg_cnt});
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 0;
        while (resp_cnt == r0 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("resp_count", 64'(resp_cnt - r0), 64'd1);
        chk("rd_en_cycles", 64'(rd_cnt - rd0), 64'(nrd));
        chk("write_count", 64'(wr_cnt - wr0), 64'(nwr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, wr0;
        repeat (2) @(negedge clk);
        chk("ready_in_rst", {63'd0, req_ready}, 64'd0);
        chk("wen_in_rst", {63'd0, mem_write_en}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_rst", {63'd0, req_ready}, 64'd1);
        chk("resp_valid_idle", {63'd0, resp_valid}, 64'd0);
        chk("rdata_idle", resp_rdata, 64'd0);
        chk("ren_idle", {63'd0, mem_read_en}, 64'd0);
        chk("waddr_idle", mem_write_addr, 64'd0);

        preload(7'd1, 64'h0102030405060708);
        preload(7'd2, 64'h1122334455667788);
        preload(7'd3, 64'h80FF010200000000);
        preload(7'd5, 64'h0);
        preload(7'd127, 64'h00000000000000AA);

        op(1'b0, 2'd0, 1'b0, 64'd17, 64'd0, 64'h22, 1'b0, 3, 1, 0);
        op(1'b0, 2'd2, 1'b1, 64'd24, 64'd0, 64'hFFFFFFFF80FF0102, 1'b0, 3, 1, 0);
        op(1'b0, 2'd2, 1'b0, 64'd24, 64'd0, 64'h0000000080FF0102, 1'b0, 3, 1, 0);
        op(1'b0, 2'd1, 1'b1, 64'd22, 64'd0, 64'h7788, 1'b0, 3, 1, 0);
        op(1'b0, 2'd1, 1'b1, 64'd24, 64'd0, 64'hFFFFFFFFFFFF80FF, 1'b0, 3, 1, 0);

        op(1'b1, 2'd0, 1'b0, 64'd19, 64'hFFFFFFFFFFFFFFAB, 64'd0, 1'b0, 4, 1, 1);
        chk("mem_idx2_after_sb", mem[2], 64'h112233AB55667788);

        op(1'b1, 2'd3, 1'b0, 64'd40, 64'hDEADBEEFCAFEF00D, 64'd0, 1'b0, 3, 0, 1);
        chk("mem_idx5_after_sd", mem[5], 64'hDEADBEEFCAFEF00D);
        op(1'b0, 2'd3, 1'b0, 64'd40, 64'd0, 64'hDEADBEEFCAFEF00D, 1'b0, 3, 1, 0);

        op(1'b0, 2'd2, 1'b0, 64'd18, 64'd0, 64'd0, 1'b1, 2, 0, 0);
        op(1'b0, 2'd3, 1'b0, 64'd1024, 64'd0, 64'd0, 1'b1, 2, 0, 0);
        op(1'b1, 2'd2, 1'b0, 64'd9, 64'h12345678, 64'd0, 1'b1, 2, 0, 0);
        op(1'b0, 2'd0, 1'b0, 64'd1023, 64'd0, 64'hAA, 1'b0, 3, 1, 0);

        // Half store to addr 8, reset asserted during its WR cycle.
        @(negedge clk);
        #1;
        req_is_store = 1'b1;
        req_size     = 2'd1;
        req_signed   = 1'b0;
        req_addr     = 64'd8;
        req_wdata    = 64'hBEEF;
        req_valid    = 1'b1;
        r0  = resp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wen_in_wr", {63'd0, mem_write_en}, 64'd1);
        wr0 = wr_cnt;
        #1 rst = 1'b1;
        #1;
        chk("wen_gated_by_rst", {63'd0, mem_write_en}, 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_wr_rst", {63'd0, req_ready}, 64'd1);
        chk("no_resp_after_rst", 64'(resp_cnt - r0), 64'd0);
        chk("no_write_after_rst", 64'(wr_cnt - wr0), 64'd0);
        chk("mem_idx1_unchanged", mem[1], 64'h0102030405060708);

        op(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, 64'h0102030405060708, 1'b0, 3, 1, 0);

        chk("rd_wr_exclusive", {63'd0, both}, 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the uPOWER execute stage and the 64-bit word-indexed data memory (128 x 64-bit entries, combinational read, posedge write).
- Converts byte-addressed load/store requests (byte/half/word/doubleword) into doubleword-index memory accesses.
- Sub-doubleword stores are done as read-modify-write; loads are zero- or sign-extended.
- Big-endian lane order; single outstanding request with valid/ready handshake.

Parameters:
- DATA_W, 64, memory/register data width
- ADDR_W, 64, request byte-address and memory-port width
- MEM_DEPTH, 128, number of doubleword entries; index = addr >> 3

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when valid&ready at posedge
- req_is_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=doubleword
- req_signed  in  1  sign-extend load result (ignored for stores and doublewords)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load result (0 for stores and errors)
- resp_err  out  1  misaligned or out-of-range, valid with resp_valid
- mem_read_en  out  1  to data memory MemRead
- mem_read_addr  out  ADDR_W  doubleword index
- mem_read_data  in  DATA_W  from data memory
- mem_write_en  out  1  to data memory MemWrite
- mem_write_addr  out  ADDR_W  doubleword index
- mem_write_data  out  DATA_W  merged doubleword

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high; the design has one clock.
- Reset values:
  - state=IDLE, req_ready=1 in the cycle after reset deasserts.
  - req_ready=0 while rst=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_read_en=0, mem_write_en=0, all address/data outputs 0.
- Request registers (addr, size, signed, is_store, wdata) are captured on accept.
- Requests are ignored unless req_ready=1. req_ready=1 only in IDLE.
- Alignment and range check, on the registered request:
  - Misaligned if addr mod (1<<size) != 0.
  - Out of range if (addr>>3) >= MEM_DEPTH.
- Lane mapping: byte offset o=addr[2:0] selects bits [63-8o : 56-8o]. Half and word fields are likewise big-endian within the doubleword.
- States and transitions:
  - IDLE: on accept, go to CHK.
  - CHK:
    - Error -> RESP with err=1; no memory access at all.
    - Load -> RD.
    - Store, size=3 -> WR.
    - Store, size<3 -> RD.
  - RD:
    - mem_read_en=1 and mem_read_addr=index, driven combinationally from the registered request.
    - mem_read_data is captured into rd_buf at the end of the cycle.
    - Load -> RESP. Store -> WR.
  - WR:
    - mem_write_en=(state==WR)&&!rst; mem_write_addr=index.
    - mem_write_data = req_wdata for a doubleword store.
    - For narrower stores, mem_write_data = rd_buf with the addressed lane replaced by the low 8/16/32 bits of req_wdata.
    - Next state RESP.
  - RESP:
    - resp_valid=1 for exactly one cycle.
    - For loads, resp_rdata is the extracted field, zero- or sign-extended per req_signed.
    - Next state IDLE.
- Latency from the accept edge to resp_valid:
  - Error: 2 cycles.
  - Load: 3 cycles.
  - Doubleword store: 3 cycles.
  - Sub-doubleword store: 4 cycles.
- Back-to-back requests: a new request can be accepted in the cycle after RESP (IDLE). There is no overlap.
- rst asserted in any state:
  - Next state is IDLE and the in-flight request is discarded.
  - No resp_valid is issued.
  - No memory write occurs in that cycle.
- Only one of mem_read_en and mem_write_en is ever high in a given cycle.

Decomposition:
- Shared package lsu_pkg holds:
  - Size encodings: SZ_B, SZ_H, SZ_W, SZ_D.
  - State encodings: IDLE, CHK, RD, WR, RESP.
  - MEM_DEPTH default.
- One sub-module, lsu_lane_align, is purely combinational:
  - Field extract plus zero/sign extension.
  - Store-lane merge.
- The FSM and request registers stay in the top module.

Test Plan:
- Byte load: preload idx2=0x1122334455667788; load byte, addr 17, unsigned -> resp_rdata=0x22, err=0, resp 3 cycles after accept.
- Signed word load: preload idx3=0x80FF0102_00000000; load word, addr 24, signed -> 0xFFFFFFFF80FF0102. Same request unsigned -> 0x0000000080FF0102.
- Byte store (read-modify-write): store byte 0xAB, addr 19, into idx2=0x1122334455667788 -> exactly one write, idx2=0x112233AB55667788, resp 4 cycles after accept.
- Doubleword store: store 0xDEADBEEFCAFEF00D, addr 40 -> idx5 written, no mem_read_en, resp 3 cycles after accept.
- Errors: load word, addr 18 -> err=1, rdata=0, no mem_read_en/mem_write_en. Load doubleword, addr 1024 -> err=1.
- Reset in WR: assert rst in the WR cycle of a half store to addr 8 -> idx1 unchanged, no resp_valid, req_ready=1 the cycle after rst falls.
